det5_laplace_seq: RTL

- Sequential controller that computes the determinant of a 5x5 signed 8-bit matrix by cofactor expansion along row 0.
- Time-shares one external combinational 4x4 determinant datapath, the det4 unit, over the five minors.
- Accumulates the signed products and reports an 8-bit determinant with an overflow flag, using a start/busy/done handshake.
- Sits between the coprocessor command logic and the det4 datapath; it replaces a fully combinational 5x5 unit to save area.

---
 rtl/det5_laplace_seq_if.sv | 27 ++
 rtl/det5_laplace_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/det5_laplace_seq_if.sv
// Bundle of signals between the 5x5 determinant controller, the command
// logic that issues requests, and the shared combinational det4 datapath.
// The slave view belongs to the controller; the master view belongs to
// whoever drives requests and supplies the det4 results.
interface det5_laplace_seq_if #(
  parameter int W = 8
);
  logic             start;
  logic [25*W-1:0]  matrix;
  logic             busy;
  logic             done;
  logic [W-1:0]     det;
  logic             ovf;
  logic [16*W-1:0]  minor;
  logic [W-1:0]     minor_det;
  logic             minor_ovf;

  modport slave (
    input  start, matrix, minor_det, minor_ovf,
    output busy, done, det, ovf, minor
  );

  modport master (
    output start, matrix, minor_det, minor_ovf,
    input  busy, done, det, ovf, minor
  );
endinterface

// File: rtl/det5_laplace_seq.sv
// Sequential 5x5 determinant by cofactor expansion along row 0.
// One external combinational det4 unit is time-shared over the five minors:
// each nonzero row-0 column costs a SETUP cycle (register the minor) and an
// ACC cycle (sample det4 and accumulate); zero columns cost one SETUP cycle.
module det5_laplace_seq #(
  parameter int W    = 8,
  parameter int ACCW = 20
) (
  input logic               clk,
  input logic               rst,
  det5_laplace_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACC,
    FIN
  } state_t;

  localparam logic signed [ACCW-1:0] ResMax = ACCW'((2 ** (W - 1)) - 1);
  localparam logic signed [ACCW-1:0] ResMin = ACCW'(-(2 ** (W - 1)));

  state_t                  state_q, state_d;
  logic [2:0]              col_q, col_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic                    ovfAcc_q, ovfAcc_d;
  logic [25*W-1:0]         mReg_q, mReg_d;
  logic [16*W-1:0]         minor_q, minor_d;
  logic [W-1:0]            det_q, det_d;
  logic                    ovf_q, ovf_d;

  logic signed [W-1:0]     pivot;
  logic signed [W-1:0]     minorDet;
  logic signed [2*W-1:0]   product;
  logic signed [ACCW-1:0]  productExt;
  logic [16*W-1:0]         minorCut;

  assign minorDet   = bus.minor_det;
  assign product    = pivot * minorDet;
  assign productExt = {{(ACCW - 2*W){product[2*W-1]}}, product};

  // Select the row-0 element of the column currently being expanded.
  always_comb begin
    pivot = mReg_q[25*W-1 - W*int'(col_q) -: W];
  end

  // Build the 4x4 minor: drop row 0 and the current column, keep order.
  always_comb begin
    minorCut = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        minorCut[16*W-1 - W*(4*r + c) -: W] =
          mReg_q[25*W-1 - W*(5*(r + 1) + ((c < int'(col_q)) ? c : c + 1)) -: W];
      end
    end
  end

  // Next-state logic; det/ovf are loaded on the edge that enters FIN so
  // they are already valid during the done cycle.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    acc_d    = acc_q;
    ovfAcc_d = ovfAcc_q;
    mReg_d   = mReg_q;
    minor_d  = minor_q;
    det_d    = det_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mReg_d   = bus.matrix;
          acc_d    = '0;
          ovfAcc_d = 1'b0;
          col_d    = 3'd0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        if (pivot == '0) begin
          if (col_q == 3'd4) begin
            state_d = FIN;
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          minor_d = minorCut;
          state_d = ACC;
        end
      end

      ACC: begin
        if (col_q[0]) begin
          acc_d = acc_q - productExt;
        end else begin
          acc_d = acc_q + productExt;
        end
        ovfAcc_d = ovfAcc_q | bus.minor_ovf;
        if (col_q == 3'd4) begin
          state_d = FIN;
        end else begin
          col_d   = col_q + 3'd1;
          state_d = SETUP;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == FIN) && (state_q != FIN)) begin
      det_d = acc_d[W-1:0];
      ovf_d = ovfAcc_d | (acc_d > ResMax) | (acc_d < ResMin);
    end
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= 3'd0;
      acc_q    <= '0;
      ovfAcc_q <= 1'b0;
      mReg_q   <= '0;
      minor_q  <= '0;
      det_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      acc_q    <= acc_d;
      ovfAcc_q <= ovfAcc_d;
      mReg_q   <= mReg_d;
      minor_q  <= minor_d;
      det_q    <= det_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == FIN);
  assign bus.det   = det_q;
  assign bus.ovf   = ovf_q;
  assign bus.minor = minor_q;

endmodule
